// File: rtl/reaction_timer_core_if.sv
// Button-in / score-out bundle between the reaction timer core and its neighbours.
// The core takes the slave view. The bench or host takes the master view.
interface reaction_timer_core_if;
    logic        btn;
    logic        b;
    logic [23:0] C;
    logic        led;
    logic        done;
    logic        foul;

    modport master (
        output btn,
        input  b,
        input  C,
        input  led,
        input  done,
        input  foul
    );

    modport slave (
        input  btn,
        output b,
        output C,
        output led,
        output done,
        output foul
    );
endinterface

// File: rtl/reaction_timer_core.sv
// Reaction timer measurement stage: a random pre-stimulus wait, then tick counting
// until the response press; drives the score C and the synchronized button b.
module reaction_timer_core #(
    parameter int unsigned TICK_DIV  = 50000,
    parameter int unsigned MIN_DELAY = 1000,
    parameter logic [15:0] RAND_MASK = 16'h0FFF,
    parameter logic [23:0] TIMEOUT   = 24'd9999
) (
    input  logic                 clk,
    input  logic                 rst,
    reaction_timer_core_if.slave bus
);
    localparam int PRESC_W = $clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_TIMING,
        ST_DONE,
        ST_FOUL
    } state_t;

    state_t               state_reg;
    state_t               state_next;
    logic [2:0]           sync_reg;     // [0]=first flop, [1]=b, [2]=b delayed
    logic [15:0]          lfsr_reg;
    logic [PRESC_W-1:0]   presc_reg;
    logic [23:0]          delay_reg;
    logic [23:0]          count_reg;
    logic [23:0]          score_reg;
    logic                 done_reg;

    logic                 press;
    logic                 tick;
    logic                 lfsr_fb;
    logic [23:0]          count_inc;
    logic [23:0]          delay_load;
    logic                 start_trial;
    logic                 arm_expire;
    logic                 time_out;
    logic                 led_level;
    logic                 foul_level;

    assign press      = sync_reg[1] & ~sync_reg[2];
    assign tick       = (presc_reg == PRESC_LAST);
    assign lfsr_fb    = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];
    assign count_inc  = count_reg + 24'd1;
    assign delay_load = 24'(MIN_DELAY) + {8'd0, lfsr_reg & RAND_MASK};

    // A press always takes priority over a same-cycle expiry or timeout tick.
    assign start_trial = press & ((state_reg == ST_IDLE) | (state_reg == ST_DONE) |
                                  (state_reg == ST_FOUL));
    assign arm_expire  = (state_reg == ST_ARMED) & ~press & tick & (delay_reg == 24'd1);
    assign time_out    = (state_reg == ST_TIMING) & ~press & tick & (count_inc == TIMEOUT);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= 3'b000;
            lfsr_reg <= 16'hACE1;
        end else begin
            sync_reg <= {sync_reg[1:0], bus.btn};
            lfsr_reg <= {lfsr_reg[14:0], lfsr_fb};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE, ST_FOUL: begin
                if (press) state_next = ST_ARMED;
            end
            ST_ARMED: begin
                if (press)           state_next = ST_FOUL;
                else if (arm_expire) state_next = ST_TIMING;
            end
            ST_TIMING: begin
                if (press || time_out) state_next = ST_DONE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        led_level  = 1'b0;
        foul_level = 1'b0;
        case (state_reg)
            ST_TIMING: led_level  = 1'b1;
            ST_FOUL:   foul_level = 1'b1;
            default: begin
                led_level  = 1'b0;
                foul_level = 1'b0;
            end
        endcase
    end

    // Prescaler restarts on entry to ARMED and TIMING so every wait/count starts on a full tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_reg <= '0;
            delay_reg <= 24'd0;
            count_reg <= 24'd0;
            score_reg <= 24'd0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (tick || start_trial || arm_expire) begin
                presc_reg <= '0;
            end else begin
                presc_reg <= presc_reg + 1'b1;
            end

            case (state_reg)
                ST_IDLE, ST_DONE, ST_FOUL: begin
                    if (press) begin
                        delay_reg <= delay_load;
                        score_reg <= 24'd0;
                    end
                end
                ST_ARMED: begin
                    if (press) begin
                        done_reg <= 1'b1;
                    end else if (tick) begin
                        if (delay_reg == 24'd1) begin
                            count_reg <= 24'd0;
                        end else begin
                            delay_reg <= delay_reg - 24'd1;
                        end
                    end
                end
                ST_TIMING: begin
                    if (press) begin
                        score_reg <= count_reg;
                        done_reg  <= 1'b1;
                    end else if (tick) begin
                        if (count_inc == TIMEOUT) begin
                            score_reg <= TIMEOUT;
                            done_reg  <= 1'b1;
                        end else begin
                            count_reg <= count_inc;
                        end
                    end
                end
                default: begin
                    done_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.b    = sync_reg[1];
    assign bus.C    = score_reg;
    assign bus.led  = led_level;
    assign bus.done = done_reg;
    assign bus.foul = foul_level;
endmodule

// File: tb/tb_reaction_timer_core.sv
// Bench for reaction_timer_core: directed trials plus random button activity,
// checked every cycle against a deadline-based trial model.
`timescale 1ns/1ps
module tb_reaction_timer_core;
    localparam int          TICK_DIV  = 4;
    localparam int          MIN_DELAY = 3;
    localparam logic [15:0] RAND_MASK = 16'h0003;
    localparam int          TIMEOUT   = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;

    reaction_timer_core_if bus_if ();

    reaction_timer_core #(
        .TICK_DIV (TICK_DIV),
        .MIN_DELAY(MIN_DELAY),
        .RAND_MASK(RAND_MASK),
        .TIMEOUT  (24'(TIMEOUT))
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Model: trial phases tracked by absolute edge deadlines instead of counters.
    localparam int P_IDLE = 0, P_ARMED = 1, P_TIMING = 2, P_DONE = 3, P_FOUL = 4;
    int          cyc = 0;
    int          m_phase = P_IDLE;
    int          m_expire = 0;
    int          m_t0 = 0;
    int          m_c = 0;
    bit          m_done = 1'b0;
    bit          m_synced = 1'b0;
    bit          h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;
    logic [15:0] m_lfsr = 16'hACE1;

    task automatic model_step();
        bit press;
        cyc++;
        if (rst) begin
            m_synced = 1'b1;
            m_phase  = P_IDLE;
            m_c      = 0;
            m_done   = 1'b0;
            h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
            m_lfsr   = 16'hACE1;
        end else begin
            press  = h2 & ~h3;
            m_done = 1'b0;
            case (m_phase)
                P_IDLE, P_DONE, P_FOUL: if (press) begin
                    m_phase  = P_ARMED;
                    m_expire = cyc + TICK_DIV * (MIN_DELAY + int'(m_lfsr & RAND_MASK));
                    m_c      = 0;
                end
                P_ARMED: begin
                    if (press) begin
                        m_phase = P_FOUL;
                        m_done  = 1'b1;
                    end else if (cyc == m_expire) begin
                        m_phase = P_TIMING;
                        m_t0    = cyc;
                    end
                end
                P_TIMING: begin
                    if (press) begin
                        m_phase = P_DONE;
                        m_c     = (cyc - m_t0 - 1) / TICK_DIV;
                        m_done  = 1'b1;
                    end else if (cyc == m_t0 + TICK_DIV * TIMEOUT) begin
                        m_phase = P_DONE;
                        m_c     = TIMEOUT;
                        m_done  = 1'b1;
                    end
                end
                default: m_phase = P_IDLE;
            endcase
            h3 = h2; h2 = h1; h1 = bus_if.btn;
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_synced) begin
            chk("b",    32'(bus_if.b),    32'(h2));
            chk("C",    32'(bus_if.C),    32'(m_c));
            chk("led",  32'(bus_if.led),  32'(m_phase == P_TIMING));
            chk("done", 32'(bus_if.done), 32'(m_done));
            chk("foul", 32'(bus_if.foul), 32'(m_phase == P_FOUL));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_led(output int t, input int budget);
        int n = 0;
        t = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus_if.led !== 1'b1 && n < budget);
        if (bus_if.led !== 1'b1) chk("led_rise_timeout", 32'(bus_if.led), 32'd1);
        t = cyc;
    endtask

    task automatic wait_done(output int t, input int budget);
        int n = 0;
        t = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus_if.done !== 1'b1 && n < budget);
        if (bus_if.done !== 1'b1) chk("done_timeout", 32'(bus_if.done), 32'd1);
        t = cyc;
    endtask

    initial begin
        int t_led, t_done, c0, delta, distinct;
        bit seen [0:15];
        foreach (seen[i]) seen[i] = 1'b0;
        bus_if.btn = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        @(negedge clk);
        chk("reset_b",    32'(bus_if.b),    0);
        chk("reset_C",    32'(bus_if.C),    0);
        chk("reset_led",  32'(bus_if.led),  0);
        chk("reset_done", 32'(bus_if.done), 0);
        chk("reset_foul", 32'(bus_if.foul), 0);

        // Normal trial: response registered 30 clks (7.5 ticks) after led rise.
        step(1);
        bus_if.btn = 1'b1;
        step(2);
        bus_if.btn = 1'b0;
        wait_led(t_led, 60);
        step(27);
        bus_if.btn = 1'b1;
        wait_done(t_done, 10);
        chk("normal_C",   32'(bus_if.C),   7);
        chk("normal_led", 32'(bus_if.led), 0);
        step(1);
        bus_if.btn = 1'b0;
        step(4);
        chk("normal_b_fell", 32'(bus_if.b), 0);
        chk("normal_C_held", 32'(bus_if.C), 7);

        // False start, then recovery into ARMED.
        bus_if.btn = 1'b1;
        step(2);
        bus_if.btn = 1'b0;
        step(2);
        bus_if.btn = 1'b1;
        wait_done(t_done, 10);
        chk("foul_flag", 32'(bus_if.foul), 1);
        chk("foul_C",    32'(bus_if.C),    0);
        chk("foul_led",  32'(bus_if.led),  0);
        step(1);
        bus_if.btn = 1'b0;
        step(3);
        bus_if.btn = 1'b1;
        step(4);
        chk("rearm_foul", 32'(bus_if.foul), 0);
        chk("rearm_led",  32'(bus_if.led),  0);
        bus_if.btn = 1'b0;

        // Timeout: never respond.
        wait_led(t_led, 60);
        wait_done(t_done, 120);
        chk("timeout_C",      32'(bus_if.C), TIMEOUT);
        chk("timeout_cycles", 32'(t_done - t_led), TICK_DIV * TIMEOUT);

        // Wait range over 50 trials with random idle gaps and response times.
        for (int k = 0; k < 50; k++) begin
            step($urandom_range(1, 8));
            bus_if.btn = 1'b1;
            c0 = cyc;
            step(1);
            bus_if.btn = 1'b0;
            wait_led(t_led, 60);
            delta = t_led - (c0 + 3);
            chk("wait_ticks_range",
                32'((delta % TICK_DIV == 0) && (delta / TICK_DIV >= 3) && (delta / TICK_DIV <= 6)), 1);
            if (delta >= 0 && delta / TICK_DIV <= 15) seen[delta / TICK_DIV] = 1'b1;
            step($urandom_range(0, 30));
            bus_if.btn = 1'b1;
            wait_done(t_done, 100);
            step(1);
            bus_if.btn = 1'b0;
            step(3);
        end
        distinct = 0;
        foreach (seen[i]) if (seen[i]) distinct++;
        chk("wait_not_constant", 32'(distinct >= 2), 1);

        // Corner: press lands exactly on the ARMED expiry tick.
        bus_if.btn = 1'b1;
        step(1);
        bus_if.btn = 1'b0;
        step(3);
        while (cyc < m_expire - 3) step(1);
        bus_if.btn = 1'b1;
        wait_done(t_done, 10);
        chk("expiry_press_foul", 32'(bus_if.foul), 1);
        chk("expiry_press_led",  32'(bus_if.led),  0);
        step(1);
        bus_if.btn = 1'b0;
        step(3);

        // Corner: reset while TIMING.
        bus_if.btn = 1'b1;
        step(1);
        bus_if.btn = 1'b0;
        wait_led(t_led, 60);
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_timing_led", 32'(bus_if.led), 0);
        chk("rst_timing_C",   32'(bus_if.C),   0);
        rst = 1'b0;

        // Random button activity with occasional resets.
        for (int k = 0; k < 600; k++) begin
            step(1);
            if ($urandom_range(0, 9) == 0) bus_if.btn = ~bus_if.btn;
            rst = ($urandom_range(0, 199) == 0);
        end
        rst = 1'b0;
        bus_if.btn = 1'b0;
        step(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
